inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 125 ++++++++++++
 tb/tb_inst_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch with redirect and decode handshake.
// Build option FETCH_SKID_EN: registered 2-entry {inst,pc} output FIFO.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_inst,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   logic [31:0] tgt;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        req_valid_q, req_valid_d;

   assign tgt = branch_target & 32'hFFFF_FFFC;

`ifndef FETCH_SKID_EN

   logic stall;

   assign stall = req_valid_q && !out_ready;

   // Priority: reset, redirect, stall (replay req_pc), plain issue.
   always_comb begin
      pc_d        = pc_q + 32'd4;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      mem_addr    = pc_q;
      if (reset) begin
         pc_d        = RESET_PC;
         req_pc_d    = RESET_PC;
         req_valid_d = 1'b0;
         mem_addr    = RESET_PC;
      end else if (branch_en) begin
         pc_d     = tgt + 32'd4;
         req_pc_d = tgt;
         mem_addr = tgt;
      end else if (stall) begin
         pc_d        = pc_q;
         req_pc_d    = req_pc_q;
         req_valid_d = req_valid_q;
         mem_addr    = req_pc_q;
      end
   end

   assign out_valid = req_valid_q && !branch_en && !reset;
   assign out_inst  = mem_inst;
   assign out_pc    = req_pc_q;

`else

   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_pc_q   [2];
   logic        rd_q, wr_q;
   logic [1:0]  cnt_q;
   logic        push, pop, can_issue;
   logic [2:0]  occ;

   assign out_valid = (cnt_q != 2'd0) && !branch_en && !reset;
   assign out_inst  = fifo_inst_q[rd_q];
   assign out_pc    = fifo_pc_q[rd_q];
   assign pop       = out_valid && out_ready;
   assign push      = req_valid_q;
   assign occ       = {1'b0, cnt_q} + {2'b00, push} - {2'b00, pop};
   assign can_issue = occ < 3'd2;

   // Issue only while the FIFO can absorb the read; otherwise hold pc.
   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = 1'b0;
      mem_addr    = pc_q;
      if (reset) begin
         pc_d     = RESET_PC;
         req_pc_d = RESET_PC;
         mem_addr = RESET_PC;
      end else if (branch_en) begin
         pc_d        = tgt + 32'd4;
         req_pc_d    = tgt;
         req_valid_d = 1'b1;
         mem_addr    = tgt;
      end else if (can_issue) begin
         pc_d        = pc_q + 32'd4;
         req_pc_d    = pc_q;
         req_valid_d = 1'b1;
      end
   end

   // FIFO: flushed by reset or redirect, else push returning read, pop on transfer.
   always_ff @(posedge clk) begin
      if (reset || branch_en) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            fifo_inst_q[wr_q] <= mem_inst;
            fifo_pc_q[wr_q]   <= req_pc_q;
            wr_q              <= !wr_q;
         end
         if (pop) begin
            rd_q <= !rd_q;
         end
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

`endif

   // Fetch state registers; reset is folded into the next-state logic.
   always_ff @(posedge clk) begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and random checks of inst_fetch against an
// in-order address stream model with a hashed code memory.
module tb_inst_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_SKID_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] mem_addr;
   logic [31:0] mem_inst = '0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   inst_fetch #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .mem_addr      (mem_addr),
      .mem_inst      (mem_inst),
      .out_valid     (out_valid),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_ready     (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] code(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Code memory: one-cycle read latency
   always @(posedge clk) mem_inst <= code(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         nxt();
         n++;
         smp();
      end
      chk("wait_valid", out_valid, 1);
   endtask

   // Scoreboard: every transfer is the next address of the ideal stream
   logic [31:0] exp_pc = RST_PC;
   logic        stall_p = 1'b0;
   logic [31:0] st_pc = '0;
   logic [31:0] st_inst = '0;

   always @(negedge clk) begin
      if (!reset && !branch_en && stall_p) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_pc", out_pc, st_pc);
         chk("stall_inst", out_inst, st_inst);
      end
      if (out_valid && out_ready) begin
         chk("seq_pc", out_pc, exp_pc);
         chk("seq_inst", out_inst, code(out_pc));
         exp_pc = exp_pc + 32'd4;
      end
      if (reset)
         exp_pc = RST_PC;
      else if (branch_en)
         exp_pc = branch_target & 32'hFFFF_FFFC;
      stall_p = out_valid && !out_ready && !reset && !branch_en;
      st_pc   = out_pc;
      st_inst = out_inst;
   end

   initial begin
      int n;
      int idle;

      nxt();
      smp();
      chk("rst_valid", out_valid, 0);
      chk("rst_addr", mem_addr, RST_PC);
      nxt();
      branch_en     = 1'b1;
      branch_target = 32'h0000_0300;
      smp();
      chk("rst_br_valid", out_valid, 0);
      chk("rst_br_addr", mem_addr, RST_PC);

      nxt();
      reset     = 1'b0;
      branch_en = 1'b0;
      smp();
      chk("issue_addr", mem_addr, RST_PC);
      wait_valid(n);
      chk("rst_lat", n, LAT);
      chk("first_pc", out_pc, RST_PC);
      chk("first_inst", out_inst, code(RST_PC));
      for (int k = 1; k < 4; k++) begin
         nxt();
         smp();
         chk("run_valid", out_valid, 1);
         chk("run_pc", out_pc, RST_PC + 32'(4 * k));
      end

      nxt();
      out_ready = 1'b0;
      smp();
      chk("stall0_pc", out_pc, 32'h10);
      for (int k = 0; k < 2; k++) begin
         nxt();
         smp();
         chk("stall_hold_pc", out_pc, 32'h10);
         chk("stall_hold_inst", out_inst, code(32'h10));
      end
      nxt();
      out_ready = 1'b1;
      smp();
      chk("stall_rel_pc", out_pc, 32'h10);
      nxt();
      smp();
      chk("after_stall_pc", out_pc, 32'h14);

      nxt();
      branch_en     = 1'b1;
      branch_target = 32'h0000_0102;
      smp();
      chk("br_squash", out_valid, 0);
      chk("br_addr", mem_addr, 32'h100);
      nxt();
      branch_en = 1'b0;
      smp();
      wait_valid(n);
      chk("br_lat", n, LAT - 1);
      chk("br_pc0", out_pc, 32'h100);
      nxt();
      smp();
      chk("br_pc1", out_pc, 32'h104);

      nxt();
      out_ready     = 1'b0;
      branch_en     = 1'b1;
      branch_target = 32'h0000_0200;
      smp();
      chk("br_stall_squash", out_valid, 0);
      nxt();
      out_ready = 1'b1;
      branch_en = 1'b0;
      smp();
      wait_valid(n);
      chk("br_stall_pc", out_pc, 32'h200);

      nxt();
      branch_en     = 1'b1;
      branch_target = 32'hFFFF_FFFE;
      smp();
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      nxt();
      branch_en = 1'b0;
      smp();
      wait_valid(n);
      chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
      nxt();
      smp();
      chk("wrap_pc1", out_pc, 32'h0000_0000);

      nxt();
      out_ready = 1'b0;
      smp();
      for (int k = 0; k < 3; k++) begin
         nxt();
         smp();
      end
      nxt();
      reset = 1'b1;
      smp();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_addr", mem_addr, RST_PC);
      nxt();
      reset     = 1'b0;
      out_ready = 1'b1;
      smp();
      wait_valid(n);
      chk("mid_rst_lat", n, LAT);
      chk("mid_rst_pc", out_pc, RST_PC);

      idle = 0;
      for (int i = 0; i < 3000; i++) begin
         nxt();
         out_ready = ($urandom_range(0, 3) != 0);
         branch_en = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0)
            branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            branch_target = $urandom;
         reset = ($urandom_range(0, 149) == 0);
         smp();
         if (out_valid || branch_en || reset)
            idle = 0;
         else
            idle++;
         chk("live", idle <= 3, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
